// File: rtl/dmem_mmio_resp_pkg.sv
// Shared address map, status-word layout and address decode for the data-memory responder.
package dmem_mmio_resp_pkg;

    localparam logic [31:0] MMIO_BASE       = 32'h1000_0000;
    localparam logic [31:0] CONS_ADDR       = MMIO_BASE + 32'h0;
    localparam logic [31:0] CYCLE_ADDR      = MMIO_BASE + 32'h4;
    localparam logic [31:0] HALT_ADDR       = MMIO_BASE + 32'h8;
    localparam logic [31:0] RAM_REGION_MASK = 32'hF000_0000;

    localparam int CONS_FULL_BIT  = 0;
    localparam int CONS_EMPTY_BIT = 1;
    localparam int CONS_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        REGION_NONE,
        REGION_RAM,
        REGION_CONS,
        REGION_CYCLE,
        REGION_HALT
    } region_e;

    // Word-granular decode; the byte-offset bits never reach this function.
    function automatic region_e decode_region(input logic [29:0] word, input int unsigned ram_words);
        logic [31:0] byte_addr;
        byte_addr = {word, 2'b00};
        if ((byte_addr & RAM_REGION_MASK) == 32'h0 && 32'(word) < ram_words) return REGION_RAM;
        if (byte_addr == CONS_ADDR)  return REGION_CONS;
        if (byte_addr == CYCLE_ADDR) return REGION_CYCLE;
        if (byte_addr == HALT_ADDR)  return REGION_HALT;
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/dmem_mmio_resp_cons_fifo.sv
// Synchronous console FIFO; pointers carry an extra MSB so full and empty are distinguishable.
module cons_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dmem_mmio_resp.sv
// Data-memory responder: word RAM plus console FIFO, cycle counter and halt register MMIO.
module dmem_mmio_resp
    import dmem_mmio_resp_pkg::*;
#(
    parameter int unsigned RAM_DEPTH  = 4096,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter              INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        cons_valid_o,
    output logic [7:0]  cons_data_o,
    input  logic        cons_ready_i,
    output logic        halt_o,
    output logic [31:0] halt_code_o,
    output logic        err_o
);

    localparam int RAM_AW  = $clog2(RAM_DEPTH);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);

    logic [31:0]      ram [RAM_DEPTH];
    logic [RAM_AW-1:0] ram_idx;
    region_e          region;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      cycle_count;
    logic             cons_push;
    logic             cons_pop;
    logic             cons_full;
    logic             cons_empty;
    logic             cons_drop;
    logic [FIFO_AW:0] cons_count;
    logic [31:0]      cons_status;
    logic             unused_byte_offset;

    assign unused_byte_offset = ^data_addr_i[1:0];

    assign region  = decode_region(data_addr_i[31:2], RAM_DEPTH);
    assign ram_idx = data_addr_i[RAM_AW+1:2];
    assign wr_en   = data_ce_i && data_we_i;
    assign rd_en   = data_ce_i && !data_we_i;

    always_ff @(posedge clk) begin
        if (wr_en && region == REGION_RAM) ram[ram_idx] <= data_i;
    end

    assign cons_valid_o = !cons_empty;
    assign cons_pop     = cons_valid_o && cons_ready_i;
    assign cons_push    = wr_en && region == REGION_CONS && !rst;
    assign cons_drop    = cons_push && cons_full && !cons_pop;

    cons_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_cons_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cons_push),
        .push_data (data_i[7:0]),
        .pop       (cons_pop),
        .head      (cons_data_o),
        .full      (cons_full),
        .empty     (cons_empty),
        .count     (cons_count)
    );

    // A CYCLE write clears the count in its own cycle, so the following cycle already reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            halt_o      <= 1'b0;
            halt_code_o <= '0;
            err_o       <= 1'b0;
        end else begin
            cycle_count <= (wr_en && region == REGION_CYCLE) ? 32'd1 : cycle_count + 32'd1;
            if (wr_en && region == REGION_HALT) begin
                halt_o      <= 1'b1;
                halt_code_o <= data_i;
            end
            if ((data_ce_i && region == REGION_NONE) || cons_drop) err_o <= 1'b1;
        end
    end

    always_comb begin
        cons_status                          = '0;
        cons_status[CONS_COUNT_LSB +: 8]     = 8'(cons_count);
        cons_status[CONS_EMPTY_BIT]          = cons_empty;
        cons_status[CONS_FULL_BIT]           = cons_full;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        data_o = '0;
        if (rd_en) begin
            case (region)
                REGION_RAM:   data_o = ram[ram_idx];
                REGION_CONS:  data_o = cons_status;
                REGION_CYCLE: data_o = cycle_count;
                REGION_HALT:  data_o = halt_code_o;
                default:      data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio_resp.sv
// Directed bench: stimulus queues expected read data and console bytes; a negedge monitor checks them.
module tb_dmem_mmio_resp;

    localparam logic [31:0] CONS  = 32'h1000_0000;
    localparam logic [31:0] CYCLE = 32'h1000_0004;
    localparam logic [31:0] HALT  = 32'h1000_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_ce_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        cons_valid_o;
    logic [7:0]  cons_data_o;
    logic        cons_ready_i = 1'b0;
    logic        halt_o;
    logic [31:0] halt_code_o;
    logic        err_o;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  cons_q[$];

    dmem_mmio_resp #(
        .RAM_DEPTH  (4096),
        .FIFO_DEPTH (8),
        .INIT_FILE  ("")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_ce_i    (data_ce_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .cons_valid_o (cons_valid_o),
        .cons_data_o  (cons_data_o),
        .cons_ready_i (cons_ready_i),
        .halt_o       (halt_o),
        .halt_code_o  (halt_code_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Each stimulus task occupies one clock cycle, starting just after the rising edge.
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        @(posedge clk); #1;
        data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = addr;
        exp_q.push_back(exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        data_ce_i = 1'b1; data_we_i = 1'b1; data_addr_i = addr; data_i = wdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            data_ce_i = 1'b0; data_we_i = 1'b0;
        end
    endtask

    // Leaves the bench in cycle 0 after reset (counter reads 0 here), with rst already low.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; data_ce_i = 1'b0; data_we_i = 1'b0; cons_ready_i = 1'b0;
        cons_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (data_ce_i && !data_we_i) begin
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL read_unexpected: data_o=%h with no expected entry", data_o);
            end else begin
                check("read_data", data_o, exp_q.pop_front());
            end
        end
        if (cons_valid_o && cons_ready_i) begin
            if (cons_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL cons_unexpected: byte=%h with no expected entry", cons_data_o);
            end else begin
                check("cons_byte", {24'h0, cons_data_o}, {24'h0, cons_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_halt", {31'h0, halt_o}, 32'h0);
        check("rst_halt_code", halt_code_o, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        check("rst_cons_valid", {31'h0, cons_valid_o}, 32'h0);
        check("rst_cons_data", {24'h0, cons_data_o}, 32'h0);
        check("rst_data_o_idle", data_o, 32'h0);
        rd(CONS, 32'h0000_0002);

        // 1: RAM write/read, byte offset ignored, data_o=0 during a write
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        @(negedge clk);
        check("data_o_on_write", data_o, 32'h0);
        rd(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0012, 32'hDEAD_BEEF);

        // 2: console push with sink stalled, then drain
        do_reset();
        wr(CONS, 32'h48); cons_q.push_back(8'h48);
        wr(CONS, 32'h69); cons_q.push_back(8'h69);
        rd(CONS, 32'h0000_0200);
        @(negedge clk);
        check("cons_valid_pending", {31'h0, cons_valid_o}, 32'h1);
        check("cons_head", {24'h0, cons_data_o}, 32'h48);
        idle(1); cons_ready_i = 1'b1;
        idle(1);
        idle(1); cons_ready_i = 1'b0;
        @(negedge clk);
        check("cons_drained", {31'h0, cons_valid_o}, 32'h0);
        rd(CONS, 32'h0000_0002);

        // Reset during a drain discards the remaining entries
        wr(CONS, 32'h41); cons_q.push_back(8'h41);
        wr(CONS, 32'h42); cons_q.push_back(8'h42);
        idle(1); cons_ready_i = 1'b1;
        do_reset();
        @(negedge clk);
        check("rst_mid_drain_valid", {31'h0, cons_valid_o}, 32'h0);
        check("rst_mid_drain_data", {24'h0, cons_data_o}, 32'h0);

        // 3a: overflow is dropped and flagged
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr(CONS, 32'h30 + 32'(i)); cons_q.push_back(8'h30 + 8'(i));
        end
        idle(1);
        @(negedge clk);
        check("full_no_err", {31'h0, err_o}, 32'h0);
        wr(CONS, 32'h38);
        idle(1);
        @(negedge clk);
        check("overflow_err", {31'h0, err_o}, 32'h1);
        rd(CONS, 32'h0000_0801);
        idle(1); cons_ready_i = 1'b1;
        idle(7);
        idle(1); cons_ready_i = 1'b0;
        @(negedge clk);
        check("overflow_drained", {31'h0, cons_valid_o}, 32'h0);

        // 3b: push into a full FIFO with a simultaneous pop is accepted
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr(CONS, 32'h30 + 32'(i)); cons_q.push_back(8'h30 + 8'(i));
        end
        wr(CONS, 32'h38); cons_ready_i = 1'b1; cons_q.push_back(8'h38);
        idle(1); cons_ready_i = 1'b0;
        @(negedge clk);
        check("push_pop_full_no_err", {31'h0, err_o}, 32'h0);
        rd(CONS, 32'h0000_0801);
        idle(1); cons_ready_i = 1'b1;
        idle(7);
        idle(1); cons_ready_i = 1'b0;

        // 4: cycle counter (cycle 0 plus 4 idles = 5 idle cycles)
        do_reset();
        idle(4);
        rd(CYCLE, 32'd5);
        wr(CYCLE, 32'hABCD_0123);
        rd(CYCLE, 32'd1);
        idle(1);
        @(negedge clk);
        force dut.cycle_count = 32'hFFFF_FFFF;
        #1 release dut.cycle_count;
        rd(CYCLE, 32'h0);

        // 5: halt register
        do_reset();
        wr(HALT, 32'h0000_002A);
        idle(1);
        @(negedge clk);
        check("halt_set", {31'h0, halt_o}, 32'h1);
        check("halt_code", halt_code_o, 32'h2A);
        rd(HALT, 32'h2A);
        wr(32'h0000_0020, 32'h1234_5678);
        rd(32'h0000_0020, 32'h1234_5678);
        wr(HALT, 32'h55);
        idle(1);
        @(negedge clk);
        check("halt_sticky", {31'h0, halt_o}, 32'h1);
        check("halt_code_update", halt_code_o, 32'h55);
        do_reset();
        @(negedge clk);
        check("halt_cleared", {31'h0, halt_o}, 32'h0);
        check("halt_code_cleared", halt_code_o, 32'h0);
        rd(32'h0000_0020, 32'h1234_5678);

        // 6: unmapped accesses, last RAM word, ce=0
        do_reset();
        rd(32'h2000_0000, 32'h0);
        idle(1);
        @(negedge clk);
        check("unmapped_err", {31'h0, err_o}, 32'h1);
        do_reset();
        wr(32'h0000_3FFC, 32'hCAFE_F00D);
        rd(32'h0000_3FFC, 32'hCAFE_F00D);
        idle(1);
        @(negedge clk);
        check("last_word_no_err", {31'h0, err_o}, 32'h0);
        rd(32'h0000_4000, 32'h0);
        idle(1);
        @(negedge clk);
        check("past_ram_err", {31'h0, err_o}, 32'h1);
        do_reset();
        idle(1); data_addr_i = 32'h2000_0000;
        @(negedge clk);
        check("ce0_data_o", data_o, 32'h0);
        idle(1);
        @(negedge clk);
        check("ce0_no_err", {31'h0, err_o}, 32'h0);

        idle(2);
        check("reads_outstanding", 32'(exp_q.size()), 32'h0);
        check("cons_outstanding", 32'(cons_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
